// File: rtl/seq_alu_acc.sv
// Registered accumulator ALU: single-cycle ops on {A, B} plus a
// shift-add unsigned multiply, sequenced by Start/Busy/Done.
module seq_alu_acc #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N-1:0]   A,
  input  logic [2:0]     Function,
  input  logic           Start,
  output logic [2*N-1:0] ALUout,
  output logic           Busy,
  output logic           Done
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(N) + 1;

  localparam logic [N:0]    SH_LIM = (N + 1)'(W);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_n;
  logic          busy;
  logic          busy_n;
  logic          done;
  logic          done_n;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mcand_n;
  logic [N-1:0]  mplier;
  logic [N-1:0]  mplier_n;
  logic [W-1:0]  prod;
  logic [W-1:0]  prod_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  logic [N-1:0]  b;
  logic [N:0]    usum;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  res;
  logic [W-1:0]  prod_add;

  assign b = acc[N-1:0];

  // Result of every single-cycle function, from A and the current B
  always_comb begin
    usum = {1'b0, A} + {1'b0, b};
    sa   = {{N{A[N-1]}}, A};
    sb   = {{N{b[N-1]}}, b};
    res  = acc;
    unique case (Function)
      3'b000: res = W'(usum);
      3'b001: res = sa + sb;
      3'b010: res = sb;
      3'b011: res = W'(|{A, b});
      3'b100: res = W'(&{A, b});
      3'b101: res = {A, b};
      3'b110: begin
        if ({1'b0, A} >= SH_LIM)
          res = '0;
        else
          res = {{N{1'b0}}, b} << A;
      end
      3'b111: res = acc;
    endcase
  end

  assign prod_add = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    busy_n   = busy;
    done_n   = 1'b0;
    mcand_n  = mcand;
    mplier_n = mplier;
    prod_n   = prod;
    cnt_n    = cnt;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (Function == 3'b111) begin
            mcand_n  = {{N{1'b0}}, A};
            mplier_n = b;
            prod_n   = '0;
            cnt_n    = '0;
            busy_n   = 1'b1;
            state_n  = MUL;
          end else begin
            acc_n  = res;
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        prod_n   = prod_add;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 1'b1;
        // Start is deliberately ignored here, including on the last edge
        if (cnt == LAST) begin
          acc_n   = prod_add;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      busy   <= busy_n;
      done   <= done_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      prod   <= prod_n;
      cnt    <= cnt_n;
    end
  end

  assign ALUout = acc;
  assign Busy   = busy;
  assign Done   = done;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Scoreboard bench for seq_alu_acc (N=4): stimulus pushes expected
// results, a negedge monitor pops one per Done pulse.
module tb_seq_alu_acc;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] A = '0;
  logic [2:0] Function = '0;
  logic       Start = 1'b0;
  logic [7:0] ALUout;
  logic       Busy;
  logic       Done;

  int tests = 0;
  int fails = 0;
  int busy_cnt;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] dummy_e;
  string      dummy_n;

  seq_alu_acc #(.N(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .A(A),
    .Function(Function),
    .Start(Start),
    .ALUout(ALUout),
    .Busy(Busy),
    .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding request
  always @(negedge Clock) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got ALUout %h required no Done",
                 ALUout);
      end else begin
        check(name_q.pop_front(), ALUout, exp_q.pop_front());
      end
      check("done_while_busy", {7'b0, Busy}, 8'h00);
    end
  end

  task automatic op(input logic [2:0] f, input logic [3:0] a,
                    input logic [7:0] e, input string nm);
    Start    = 1'b1;
    Function = f;
    A        = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge Clock);
  endtask

  task automatic load(input logic [3:0] x);
    op(3'b100, 4'h0, 8'h00, "load_clear");
    op(3'b000, x, {4'h0, x}, "load");
  endtask

  task automatic idle();
    Start = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    #1 Reset = 1'b1;
    #11;
    check("reset_aluout", ALUout, 8'h00);
    check("reset_busy", {7'b0, Busy}, 8'h00);
    check("reset_done", {7'b0, Done}, 8'h00);
    @(negedge Clock);
    Reset = 1'b0;

    op(3'b000, 4'b1011, 8'h0B, "first_load");
    op(3'b000, 4'b0111, 8'h12, "uadd_carry");
    load(4'b1011);
    op(3'b001, 4'b0111, 8'h02, "sadd");
    op(3'b010, 4'h0, 8'h02, "sext_pos");
    load(4'b1011);
    op(3'b010, 4'h0, 8'hFB, "sext_neg");
    load(4'b1011);
    op(3'b100, 4'b0000, 8'h00, "and_reduce");
    load(4'b1011);
    op(3'b011, 4'b0000, 8'h01, "or_reduce");
    load(4'b1011);
    op(3'b101, 4'b0101, 8'h5B, "concat");
    load(4'b0011);
    op(3'b110, 4'd3, 8'h18, "shl_3");
    load(4'b0011);
    op(3'b110, 4'd8, 8'h00, "shl_ge_2n");
    load(4'b0011);
    op(3'b110, 4'd7, 8'h80, "shl_7");
    idle();
    idle();
    check("done_low_idle", {7'b0, Done}, 8'h00);

    load(4'b1111);
    op(3'b111, 4'b1111, 8'hE1, "mul_15x15");
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Busy) break;
      busy_cnt++;
      check("mul_hold", ALUout, 8'h0F);
      if (busy_cnt == 2) begin
        Start    = 1'b1;
        Function = 3'b000;
        A        = 4'h1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    check("mul_busy_cycles", 8'(busy_cnt), 8'd4);
    check("mul_done_hi", {7'b0, Done}, 8'h01);
    @(negedge Clock);
    check("mul_done_pulse", {7'b0, Done}, 8'h00);
    check("mul_result_kept", ALUout, 8'hE1);

    load(4'b0011);
    op(3'b111, 4'b0101, 8'h0F, "mul_abort");
    Start = 1'b0;
    check("abort_busy", {7'b0, Busy}, 8'h01);
    @(negedge Clock);
    dummy_e = exp_q.pop_back();
    dummy_n = name_q.pop_back();
    #2 Reset = 1'b1;
    #1;
    check("abort_aluout", ALUout, 8'h00);
    check("abort_busy_low", {7'b0, Busy}, 8'h00);
    check("abort_done", {7'b0, Done}, 8'h00);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      check("abort_no_done", {7'b0, Done}, 8'h00);
    end
    op(3'b000, 4'b0001, 8'h01, "post_reset_add");
    idle();
    idle();

    check("pending_results", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
